// File: rtl/fetch_sequencer.sv
// T-state sequencer: two fetch steps (address, data) followed by microcode exec steps.
// Define WAIT_STATE_EN to stretch T1 until mem_ready is high.
module fetch_sequencer #(
    parameter int unsigned NSTEPS = 8,
    parameter int unsigned STEPW  = 3
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             halt,
    input  logic             done_bar,
    input  logic             mem_ready,
    output logic [STEPW-1:0] step,
    output logic             pc_out_bar,
    output logic             ar_load_bar,
    output logic             mem_out_bar,
    output logic             ir_load_bar,
    output logic             pc_inc,
    output logic             exec,
    output logic             halted,
    output logic [15:0]      instr_count
);

    typedef enum logic [1:0] {
        PhAddr,
        PhData,
        PhExec
    } phase_e;

    phase_e           phase;
    logic [STEPW-1:0] step_q, step_d;
    logic [15:0]      count_q, count_d;
    logic             data_ok;
    logic             last_step;

`ifdef WAIT_STATE_EN
    assign data_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign data_ok          = 1'b1;
`endif

    assign last_step = (step_q >= STEPW'(NSTEPS - 1));

    always_comb begin
        phase = PhExec;
        if (step_q == '0) begin
            phase = PhAddr;
        end else if (step_q == STEPW'(1)) begin
            phase = PhData;
        end
    end

    always_comb begin
        step_d  = step_q;
        count_d = count_q;
        unique case (phase)
            PhAddr: begin
                if (!halt) begin
                    step_d = STEPW'(1);
                end
            end
            PhData: begin
                if (data_ok) begin
                    step_d  = STEPW'(2);
                    count_d = count_q + 16'd1;
                end
            end
            PhExec: begin
                // Early end and final-step wrap both return to the fetch address step.
                if (!done_bar || last_step) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEPW'(1);
                end
            end
            default: step_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            step_q  <= '0;
            count_q <= '0;
        end else begin
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    // Strobes are gated by reset so nothing drives the bus while reset is held.
    always_comb begin
        pc_out_bar  = 1'b1;
        ar_load_bar = 1'b1;
        mem_out_bar = 1'b1;
        ir_load_bar = 1'b1;
        pc_inc      = 1'b0;
        exec        = 1'b0;
        halted      = 1'b0;
        if (reset_bar) begin
            unique case (phase)
                PhAddr: begin
                    if (halt) begin
                        halted = 1'b1;
                    end else begin
                        pc_out_bar  = 1'b0;
                        ar_load_bar = 1'b0;
                    end
                end
                PhData: begin
                    mem_out_bar = 1'b0;
                    ir_load_bar = !data_ok;
                    pc_inc      = data_ok;
                end
                PhExec: begin
                    exec = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign step        = step_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle scoreboard of a reference model
// plus directed checks for reset, early end, halt, wait states and counter wrap.
module tb_fetch_sequencer;

    localparam int unsigned NSTEPS = 8;
    localparam int unsigned STEPW  = 3;

    logic             clk = 1'b0;
    logic             reset_bar, halt, done_bar, mem_ready;
    logic [STEPW-1:0] step;
    logic             pc_out_bar, ar_load_bar, mem_out_bar, ir_load_bar, pc_inc, exec, halted;
    logic [15:0]      instr_count;

    fetch_sequencer #(.NSTEPS(NSTEPS), .STEPW(STEPW)) dut (
        .clk        (clk),
        .reset_bar  (reset_bar),
        .halt       (halt),
        .done_bar   (done_bar),
        .mem_ready  (mem_ready),
        .step       (step),
        .pc_out_bar (pc_out_bar),
        .ar_load_bar(ar_load_bar),
        .mem_out_bar(mem_out_bar),
        .ir_load_bar(ir_load_bar),
        .pc_inc     (pc_inc),
        .exec       (exec),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [STEPW-1:0] step;
        logic             pcb, arb, memb, irb, inc, ex, hlt;
        logic [15:0]      count;
    } exp_t;

    exp_t             sb[$];
    logic [STEPW-1:0] m_step;
    logic [15:0]      m_count;
    int               checks   = 0;
    int               failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic data_ok();
`ifdef WAIT_STATE_EN
        return mem_ready;
`else
        return 1'b1;
`endif
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.step = m_step; e.count = m_count;
        e.pcb = 1; e.arb = 1; e.memb = 1; e.irb = 1; e.inc = 0; e.ex = 0; e.hlt = 0;
        if (reset_bar) begin
            if (m_step == 0) begin
                if (halt) e.hlt = 1;
                else begin e.pcb = 0; e.arb = 0; end
            end else if (m_step == 1) begin
                e.memb = 0;
                e.irb  = !data_ok();
                e.inc  = data_ok();
            end else begin
                e.ex = 1;
            end
        end
        return e;
    endfunction

    function automatic void advance();
        if (!reset_bar) begin
            m_step = 0; m_count = 0;
        end else if (m_step == 0) begin
            if (!halt) m_step = 1;
        end else if (m_step == 1) begin
            if (data_ok()) begin m_step = 2; m_count = m_count + 16'd1; end
        end else if (!done_bar || m_step == STEPW'(NSTEPS - 1)) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1'b1;
        end
    endfunction

    // One clock: predict, sample on the falling edge, then advance the model past the rise.
    task automatic tick();
        exp_t e;
        sb.push_back(predict());
        @(negedge clk);
        e = sb.pop_front();
        chk("step", 32'(step), 32'(e.step));
        chk("strobes", {pc_out_bar, ar_load_bar, mem_out_bar, ir_load_bar, pc_inc, exec, halted},
            {e.pcb, e.arb, e.memb, e.irb, e.inc, e.ex, e.hlt});
        chk("instr_count", 32'(instr_count), 32'(e.count));
        chk("one_driver", 32'(!pc_out_bar && !mem_out_bar), 32'd0);
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic run_to(input int s);
        int n = 0;
        while (m_step != STEPW'(s) && n < 2 * NSTEPS) begin tick(); n++; end
        chk("run_to_bound", 32'(m_step), 32'(s));
    endtask

    initial begin
        logic [STEPW-1:0] seq[16];
        logic [15:0]      c0;

        reset_bar = 0; halt = 0; done_bar = 1; mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        m_step = 0; m_count = 0;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_bars", {pc_out_bar, ar_load_bar, mem_out_bar, ir_load_bar}, 4'hf);
        chk("rst_count", 32'(instr_count), 32'd0);
        reset_bar = 1;
        #1;
        chk("rel_pc_ar", {pc_out_bar, ar_load_bar}, 2'b00);

        // Free run: two full instructions.
        for (int i = 0; i < 16; i++) begin
            seq[i] = step;
            chk("irload_only_t1", 32'(!ir_load_bar && step != 1), 32'd0);
            tick();
        end
        for (int i = 0; i < 16; i++) chk("free_seq", 32'(seq[i]), 32'(i % 8));
        chk("free_count", 32'(instr_count), 32'd2);

        // Early end in step 3; done_bar low during fetch must be ignored.
        c0 = instr_count;
        done_bar = 0;
        tick(); tick();
        done_bar = 1;
        tick();
        chk("early_s3", 32'(step), 32'd3);
        done_bar = 0;
        tick();
        done_bar = 1;
        chk("early_next", 32'(step), 32'd0);
        chk("early_count", 32'(instr_count), 32'(c0 + 16'd1));

        // Halt raised mid-instruction parks at T0 after finishing it.
        run_to(5);
        halt = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("halt_at0", 32'(step), 32'd0);
        repeat (3) tick();
        chk("halt_hold", {32'(step), 31'd0, halted}, {32'd0, 32'd1});
        chk("halt_bars", {pc_out_bar, ar_load_bar}, 2'b11);
        halt = 0;
        tick();
        chk("unhalt", 32'(step), 32'd1);

`ifdef WAIT_STATE_EN
        // Memory wait states stretch T1.
        run_to(1);
        c0 = instr_count;
        mem_ready = 0;
        repeat (3) tick();
        chk("wait_hold", {32'(step), 30'd0, ir_load_bar, mem_out_bar}, {32'd1, 32'd2});
        chk("wait_count", 32'(instr_count), 32'(c0));
        mem_ready = 1;
        #1;
        chk("wait_irload", 32'(ir_load_bar), 32'd0);
        tick();
        chk("wait_next", 32'(step), 32'd2);
`else
        // mem_ready is ignored without wait states.
        run_to(1);
        mem_ready = 0;
        tick();
        mem_ready = 1;
        chk("nowait_next", 32'(step), 32'd2);
`endif

        // Reset mid-instruction.
        run_to(4);
        reset_bar = 0;
        tick();
        reset_bar = 1;
        chk("midrst", {32'(step), 16'd0, instr_count}, 64'd0);

        // Preload the counter to its maximum, then one more fetch wraps.
        run_to(0);
        force dut.count_q = 16'hffff;
        release dut.count_q;
        m_count = 16'hffff;
        #1;
        chk("preload", 32'(instr_count), 32'hffff);
        repeat (NSTEPS) tick();
        chk("wrap", 32'(instr_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
